// File: rtl/mem_rd_arbiter.sv
// Two-port read arbiter: icache and dcache share one downstream read channel.
// One transaction outstanding at a time; round-robin on simultaneous requests;
// the icache may flush its owned transaction, whose remaining beats are then
// consumed without being forwarded.
module mem_rd_arbiter #(
    parameter int unsigned DC_FIRST = 1
) (
    input  logic        clk,
    input  logic        resetn,
    // icache request / return
    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    input  logic        ic_cancel,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,
    // dcache request / return
    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,
    // shared downstream channel
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    // owner / last_grant: 1 = dcache, 0 = icache
    localparam logic LAST_GRANT_RST = (DC_FIRST != 0) ? 1'b0 : 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        drop_q, drop_d;
    logic        rd_req_q, rd_req_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic [31:0] rd_addr_q, rd_addr_d;

    logic grant_ic, grant_dc;
    logic beat_in, drop_now, beat_ic, beat_dc;

    // Grant decision: only in IDLE and out of reset; round-robin on a tie
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (resetn && state_q == IDLE) begin
            if (ic_rd_req && dc_rd_req) begin
                grant_dc = ~last_grant_q;
                grant_ic = last_grant_q;
            end else begin
                grant_ic = ic_rd_req;
                grant_dc = dc_rd_req;
            end
        end
    end

    // Return routing: a cancel in the same cycle as a beat already drops that beat
    always_comb begin
        beat_in  = resetn && (state_q == DATA) && ret_valid;
        drop_now = drop_q | (ic_cancel & ~owner_q);
        beat_ic  = beat_in & ~owner_q & ~drop_now;
        beat_dc  = beat_in & owner_q;
    end

    // Next-state computation for the FSM and all registered outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        rd_req_d     = rd_req_q;
        beat_cnt_d   = beat_cnt_q;
        rd_type_d    = rd_type_q;
        rd_addr_d    = rd_addr_q;
        case (state_q)
            IDLE: begin
                if (grant_ic || grant_dc) begin
                    state_d      = ADDR;
                    owner_d      = grant_dc;
                    last_grant_d = grant_dc;
                    drop_d       = 1'b0;
                    rd_req_d     = 1'b1;
                    beat_cnt_d   = '0;
                    rd_type_d    = grant_dc ? dc_rd_type : ic_rd_type;
                    rd_addr_d    = grant_dc ? dc_rd_addr : ic_rd_addr;
                end
            end
            ADDR: begin
                if (ic_cancel && !owner_q) drop_d = 1'b1;
                if (rd_rdy) begin
                    rd_req_d = 1'b0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (ic_cancel && !owner_q) drop_d = 1'b1;
                if (ret_valid) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (ret_last) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
            drop_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            beat_cnt_q   <= '0;
            rd_type_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            rd_req_q     <= rd_req_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_type_q    <= rd_type_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // Output drive
    always_comb begin
        ic_rd_rdy    = grant_ic;
        dc_rd_rdy    = grant_dc;
        ic_ret_valid = beat_ic;
        ic_ret_last  = beat_ic & ret_last;
        ic_ret_data  = beat_ic ? ret_data : '0;
        dc_ret_valid = beat_dc;
        dc_ret_last  = beat_dc & ret_last;
        dc_ret_data  = beat_dc ? ret_data : '0;
        rd_req       = rd_req_q;
        rd_type      = rd_type_q;
        rd_addr      = rd_addr_q;
        busy         = resetn && (state_q != IDLE);
    end

    a_addr_no_beats: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == ADDR) |-> (beat_cnt_q == 3'd0));
    a_rdy_only_idle: assert property (@(posedge clk) disable iff (!resetn)
        (ic_rd_rdy || dc_rd_rdy) |-> (state_q == IDLE));

endmodule
